// File: rtl/writeback_stage_pkg.sv
// Shared CPU constants for the writeback stage: write-back source select,
// load type encodings and the captured-instruction record.
package writeback_stage_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  // Source of the register file write data
  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_LINK = 2'd2,
    WB_RSVD = 2'd3
  } wb_sel_e;

  // Load flavours; encodings 5-7 are unused and treated as a word load
  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_B  = 3'd1,
    LD_BU = 3'd2,
    LD_H  = 3'd3,
    LD_HU = 3'd4
  } load_type_e;

  // Everything the stage keeps about one instruction
  typedef struct packed {
    logic                  reg_write;
    wb_sel_e               wb_sel;
    logic [2:0]            load_type;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       alu_result;
    logic [XLEN-1:0]       mem_data;
    logic [XLEN-1:0]       link_pc;
  } wb_instr_t;

  // True for the halfword load flavours, which need a halfword-aligned address
  function automatic logic is_half_load(input logic [2:0] load_type);
    return (load_type == LD_H) || (load_type == LD_HU);
  endfunction

  // True for the byte load flavours, which can never be misaligned
  function automatic logic is_byte_load(input logic [2:0] load_type);
    return (load_type == LD_B) || (load_type == LD_BU);
  endfunction

endpackage

// File: rtl/writeback_stage_load_extract.sv
// Combinational load data extraction: selects the addressed byte or halfword
// of the aligned memory word (little-endian), extends it, and flags
// addresses that are not naturally aligned for the access size.
module load_extract
  import writeback_stage_pkg::*;
(
  input  logic [2:0]      load_type,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] mem_data,
  output logic [XLEN-1:0] load_data,
  output logic            misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte/halfword, then extend according to the load type
  always_comb begin
    byte_sel   = mem_data[{offset, 3'b000} +: 8];
    half_sel   = offset[1] ? mem_data[31:16] : mem_data[15:0];
    load_data  = mem_data;
    misaligned = 1'b0;
    if (is_byte_load(load_type)) begin
      if (load_type == LD_B) begin
        load_data = {{24{byte_sel[7]}}, byte_sel};
      end else begin
        load_data = {24'b0, byte_sel};
      end
    end else if (is_half_load(load_type)) begin
      misaligned = offset[0];
      if (load_type == LD_H) begin
        load_data = {{16{half_sel[15]}}, half_sel};
      end else begin
        load_data = {16'b0, half_sel};
      end
    end else begin
      load_data  = mem_data;
      misaligned = (offset != 2'b00);
    end
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback pipeline stage: holds one instruction from MEM, drives the
// register file write port and forwarding bus from that register, flags
// misaligned loads and counts retired instructions.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  In_Valid,
  output logic                  In_Ready,
  input  logic                  Flush,
  input  logic                  Hold,
  input  logic                  Reg_Write,
  input  logic [1:0]            Wb_Sel,
  input  logic [2:0]            Load_Type,
  input  logic [4:0]            Rd,
  input  logic [31:0]           ALU_Result,
  input  logic [31:0]           Mem_Data,
  input  logic [31:0]           Link_PC,
  output logic                  Write_Reg,
  output logic [4:0]            W_Addr,
  output logic [31:0]           W_Data,
  output logic                  Fwd_Valid,
  output logic [4:0]            Fwd_Addr,
  output logic [31:0]           Fwd_Data,
  output logic                  Misalign_Err,
  output logic [RETIRE_W-1:0]   Retired
);

  logic        stage_valid;
  wb_instr_t   stage;
  wb_instr_t   incoming;
  logic        transfer;
  logic        present;
  logic        retire;
  logic        misaligned;
  logic        ext_misaligned;
  logic [31:0] load_data;
  logic [31:0] wb_data;
  logic        wb_enable;

  assign In_Ready = !Hold;
  assign transfer = In_Valid & In_Ready & !Flush;

  // An instruction is presented to the register file only in an unheld cycle;
  // it leaves the stage at the end of that cycle and retires unless flushed.
  assign present = stage_valid & !Hold;
  assign retire  = present & !Flush;

  // Pack the MEM-stage fields into one record for capture
  always_comb begin
    incoming            = '0;
    incoming.reg_write  = Reg_Write;
    incoming.wb_sel     = wb_sel_e'(Wb_Sel);
    incoming.load_type  = Load_Type;
    incoming.rd         = Rd;
    incoming.alu_result = ALU_Result;
    incoming.mem_data   = Mem_Data;
    incoming.link_pc    = Link_PC;
  end

  // Stage register: flush beats hold beats transfer; no transfer makes a bubble
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      stage_valid <= 1'b0;
      stage       <= '0;
    end else if (Flush) begin
      stage_valid <= 1'b0;
    end else if (!Hold) begin
      stage_valid <= transfer;
      if (transfer) begin
        stage <= incoming;
      end
    end
  end

  // Retired-instruction counter, wraps naturally at its width
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Retired <= '0;
    end else if (retire) begin
      Retired <= Retired + 1'b1;
    end
  end

  load_extract u_load_extract (
    .load_type  (stage.load_type),
    .offset     (stage.alu_result[1:0]),
    .mem_data   (stage.mem_data),
    .load_data  (load_data),
    .misaligned (ext_misaligned)
  );

  assign misaligned = (stage.wb_sel == WB_MEM) & ext_misaligned;

  // Select write data by source; the reserved select drives zero
  always_comb begin
    wb_data = '0;
    case (stage.wb_sel)
      WB_ALU:  wb_data = stage.alu_result;
      WB_MEM:  wb_data = load_data;
      WB_LINK: wb_data = stage.link_pc;
      default: wb_data = '0;
    endcase
  end

  // A write needs a real destination, a usable source and an aligned access
  always_comb begin
    wb_enable = present & stage.reg_write & (stage.rd != 5'd0) &
                !misaligned & (stage.wb_sel != WB_RSVD);
  end

  assign Write_Reg    = wb_enable;
  assign W_Addr       = stage.rd;
  assign W_Data       = wb_data;
  assign Fwd_Valid    = wb_enable;
  assign Fwd_Addr     = stage.rd;
  assign Fwd_Data     = wb_data;
  assign Misalign_Err = present & misaligned;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard testbench for writeback_stage: a reference model predicts the
// writeback event of every instruction leaving the stage, a monitor compares
// what the DUT presents on each falling edge.
module tb_writeback_stage;

  localparam int RW = 6;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          In_Valid;
  logic          In_Ready;
  logic          Flush;
  logic          Hold;
  logic          Reg_Write;
  logic [1:0]    Wb_Sel;
  logic [2:0]    Load_Type;
  logic [4:0]    Rd;
  logic [31:0]   ALU_Result;
  logic [31:0]   Mem_Data;
  logic [31:0]   Link_PC;
  logic          Write_Reg;
  logic [4:0]    W_Addr;
  logic [31:0]   W_Data;
  logic          Fwd_Valid;
  logic [4:0]    Fwd_Addr;
  logic [31:0]   Fwd_Data;
  logic          Misalign_Err;
  logic [RW-1:0] Retired;

  writeback_stage #(.RETIRE_W(RW)) dut (
    .Clk(Clk), .Reset(Reset), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Flush(Flush), .Hold(Hold), .Reg_Write(Reg_Write), .Wb_Sel(Wb_Sel),
    .Load_Type(Load_Type), .Rd(Rd), .ALU_Result(ALU_Result),
    .Mem_Data(Mem_Data), .Link_PC(Link_PC), .Write_Reg(Write_Reg),
    .W_Addr(W_Addr), .W_Data(W_Data), .Fwd_Valid(Fwd_Valid),
    .Fwd_Addr(Fwd_Addr), .Fwd_Data(Fwd_Data), .Misalign_Err(Misalign_Err),
    .Retired(Retired)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        rw;
    logic [1:0]  sel;
    logic [2:0]  lt;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [31:0] link;
  } instr_t;

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        mis;
  } event_t;

  event_t exp_q[$];
  instr_t held;
  bit     held_v;
  int     exp_retired;
  bit     exp_ready;
  bit     mon_en;
  int     vectors;
  int     miscompares;
  bit     cur_valid, cur_hold, cur_flush;
  instr_t cur_ins;
  instr_t idle;

  // Reference: what an instruction should do when it writes back
  function automatic event_t predict(input instr_t i);
    event_t e;
    int off, b, h;
    logic [31:0] d;
    bit mis;
    off = int'(i.alu % 4);
    mis = 0;
    d   = 0;
    if (i.sel == 0) d = i.alu;
    else if (i.sel == 2) d = i.link;
    else if (i.sel == 1) begin
      if (i.lt == 1 || i.lt == 2) begin
        b = int'((i.mem >> (8 * off)) & 32'hFF);
        d = (i.lt == 1 && b >= 128) ? 32'(b - 256) : 32'(b);
      end else if (i.lt == 3 || i.lt == 4) begin
        mis = (off % 2) != 0;
        h = int'((i.mem >> (16 * (off / 2))) & 32'hFFFF);
        d = (i.lt == 3 && h >= 32768) ? 32'(h - 65536) : 32'(h);
      end else begin
        mis = (off != 0);
        d = i.mem;
      end
    end
    e.wr   = i.rw && (i.rd != 0) && !mis && (i.sel != 3);
    e.addr = i.rd;
    e.data = d;
    e.mis  = mis;
    return e;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    i.rw   = ($urandom_range(0, 9) != 0);
    i.sel  = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'd1;
    i.lt   = 3'($urandom_range(0, 7));
    i.rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    i.alu  = $urandom;
    i.mem  = $urandom;
    i.link = $urandom;
    return i;
  endfunction

  function automatic instr_t mk(input logic rw, input logic [1:0] sel, input logic [2:0] lt,
                                input logic [4:0] rd, input logic [31:0] alu,
                                input logic [31:0] mem, input logic [31:0] link);
    instr_t i;
    i.rw = rw; i.sel = sel; i.lt = lt; i.rd = rd; i.alu = alu; i.mem = mem; i.link = link;
    return i;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs (called just after a rising edge) and queue the
  // event the stage should present during this cycle
  task automatic drive(input bit valid, input bit hold, input bit flush, input instr_t ins);
    event_t ev;
    In_Valid = valid; Hold = hold; Flush = flush;
    Reg_Write = ins.rw; Wb_Sel = ins.sel; Load_Type = ins.lt; Rd = ins.rd;
    ALU_Result = ins.alu; Mem_Data = ins.mem; Link_PC = ins.link;
    cur_valid = valid; cur_hold = hold; cur_flush = flush; cur_ins = ins;
    exp_ready = !hold;
    if (held_v && !hold) begin
      ev = predict(held);
      if (ev.wr || ev.mis) exp_q.push_back(ev);
    end
  endtask

  // Advance to the next edge and update the reference stage and count
  task automatic step();
    @(posedge Clk);
    #1;
    if (held_v && !cur_hold && !cur_flush) exp_retired = (exp_retired + 1) % (1 << RW);
    if (cur_flush) held_v = 0;
    else if (!cur_hold) begin
      held_v = cur_valid;
      if (cur_valid) held = cur_ins;
    end
  endtask

  task automatic apply_stimulus(input bit valid, input bit hold, input bit flush, input instr_t ins);
    drive(valid, hold, flush, ins);
    step();
  endtask

  // Release reset at a falling edge with an instruction already offered, so
  // the very first edge after release must accept it
  task automatic release_reset(input instr_t first);
    @(negedge Clk);
    drive(1, 0, 0, first);
    Reset = 1'b1;
    step();
    mon_en = 1;
  endtask

  // Assert reset mid-cycle (called just after a rising edge) and check that
  // everything drops immediately
  task automatic reset_dut(input bit hold);
    event_t ev;
    mon_en = 0;
    drive(0, hold, 0, idle);
    #2;
    if (held_v && !hold) begin
      ev = predict(held);
      check_output("pre_reset_write_reg", 32'(Write_Reg), 32'(ev.wr));
    end
    Reset = 1'b0;
    #1;
    check_output("rst_write_reg", 32'(Write_Reg), 0);
    check_output("rst_fwd_valid", 32'(Fwd_Valid), 0);
    check_output("rst_misalign", 32'(Misalign_Err), 0);
    check_output("rst_retired", 32'(Retired), 0);
    check_output("rst_w_data", W_Data, 0);
    check_output("rst_w_addr", 32'(W_Addr), 0);
    exp_q.delete();
    held_v = 0;
    exp_retired = 0;
    @(posedge Clk);
    #1;
    check_output("rst_hold_write_reg", 32'(Write_Reg), 0);
    release_reset(rand_instr());
  endtask

  // Monitor: per-cycle ready/count checks and scoreboard pops on any output
  always @(negedge Clk) begin
    event_t e;
    if (mon_en) begin
      check_output("in_ready", 32'(In_Ready), 32'(exp_ready));
      check_output("retired", 32'(Retired), 32'(exp_retired));
      if (Write_Reg || Fwd_Valid || Misalign_Err) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_output", {29'b0, Write_Reg, Fwd_Valid, Misalign_Err}, 0);
        end else begin
          e = exp_q.pop_front();
          check_output("write_reg", 32'(Write_Reg), 32'(e.wr));
          check_output("fwd_valid", 32'(Fwd_Valid), 32'(e.wr));
          check_output("misalign_err", 32'(Misalign_Err), 32'(e.mis));
          if (e.wr) begin
            check_output("w_addr", 32'(W_Addr), 32'(e.addr));
            check_output("fwd_addr", 32'(Fwd_Addr), 32'(e.addr));
            check_output("w_data", W_Data, e.data);
            check_output("fwd_data", Fwd_Data, e.data);
          end
        end
      end
    end
  end

  // Directed scenarios, then randomized traffic with occasional resets
  initial begin
    instr_t ins;
    vectors = 0; miscompares = 0; mon_en = 0; held_v = 0; exp_retired = 0; exp_ready = 1;
    idle = mk(0, 0, 0, 0, 0, 0, 0);
    Reset = 1'b0;
    drive(0, 0, 0, idle);
    #3;
    check_output("init_write_reg", 32'(Write_Reg), 0);
    check_output("init_fwd_valid", 32'(Fwd_Valid), 0);
    check_output("init_misalign", 32'(Misalign_Err), 0);
    check_output("init_retired", 32'(Retired), 0);
    @(posedge Clk);
    #1;

    // ALU write accepted at the first edge after reset release
    release_reset(mk(1, 0, 0, 5'd5, 32'h12345678, 32'h0, 32'h0));
    drive(0, 0, 0, idle);
    #3;
    check_output("alu_write_reg", 32'(Write_Reg), 1);
    check_output("alu_w_addr", 32'(W_Addr), 5);
    check_output("alu_w_data", W_Data, 32'h12345678);
    step();
    drive(0, 0, 0, idle);
    #3;
    check_output("alu_retired", 32'(Retired), 1);
    step();

    // Load extraction fixed cases
    apply_stimulus(1, 0, 0, mk(1, 1, 1, 5'd3, 32'h102, 32'h80FF7F01, 0));
    drive(0, 0, 0, idle); #3; check_output("lb_sext", W_Data, 32'hFFFFFFFF); step();
    apply_stimulus(1, 0, 0, mk(1, 1, 2, 5'd3, 32'h103, 32'h80FF7F01, 0));
    drive(0, 0, 0, idle); #3; check_output("lbu_zext", W_Data, 32'h00000080); step();
    apply_stimulus(1, 0, 0, mk(1, 1, 3, 5'd3, 32'h102, 32'h80FF7F01, 0));
    drive(0, 0, 0, idle); #3; check_output("lh_sext", W_Data, 32'hFFFF80FF); step();

    // Misaligned word load: held once, then a single pulse with no write
    apply_stimulus(1, 0, 0, mk(1, 1, 0, 5'd7, 32'h201, 32'hCAFEF00D, 0));
    drive(0, 1, 0, idle); #3; check_output("mis_held_pulse", 32'(Misalign_Err), 0); step();
    drive(0, 0, 0, idle); #3;
    check_output("mis_pulse", 32'(Misalign_Err), 1);
    check_output("mis_no_write", 32'(Write_Reg), 0);
    step();
    drive(0, 0, 0, idle); #3; check_output("mis_pulse_end", 32'(Misalign_Err), 0); step();

    // jal to x0: no write, still retires
    apply_stimulus(1, 0, 0, mk(1, 2, 0, 5'd0, 32'h0, 32'h0, 32'h400));
    drive(0, 0, 0, idle); #3; check_output("jal_x0_write", 32'(Write_Reg), 0); step();

    // Three held cycles, then one write on release
    apply_stimulus(1, 0, 0, mk(1, 0, 0, 5'd9, 32'hA5A5_0009, 0, 0));
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 0, rand_instr()); #3;
      check_output("hold_ready", 32'(In_Ready), 0);
      check_output("hold_write", 32'(Write_Reg), 0);
      step();
    end
    drive(0, 0, 0, idle); #3;
    check_output("hold_release_write", 32'(Write_Reg), 1);
    check_output("hold_release_addr", 32'(W_Addr), 9);
    step();

    // Flush while held with a new instruction offered
    apply_stimulus(1, 0, 0, mk(1, 0, 0, 5'd10, 32'h0000_1010, 0, 0));
    apply_stimulus(1, 1, 1, mk(1, 0, 0, 5'd11, 32'h0000_1111, 0, 0));
    drive(0, 0, 0, idle); #3; check_output("flush_no_write", 32'(Write_Reg), 0); step();

    // Reset mid-hold and mid-write
    apply_stimulus(1, 0, 0, mk(1, 0, 0, 5'd12, 32'h0000_1212, 0, 0));
    reset_dut(1);
    reset_dut(0);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      if (n == 700 || n == 1200) reset_dut($urandom_range(0, 1) == 1);
      else apply_stimulus($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 9) == 0, rand_instr());
    end
    for (int n = 0; n < 4; n++) apply_stimulus(0, 0, 0, idle);

    mon_en = 0;
    check_output("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have parameter: RETIRE_W, 32, width of retired-instruction counter.
REQ-002 SHALL have ports, clock and reset first:
  Clk  in  1  single clock, rising edge
  Reset  in  1  asynchronous, active-low reset
  In_Valid  in  1  MEM stage presents an instruction
  In_Ready  out  1  stage accepts this cycle
  Flush  in  1  discard held and incoming instruction
  Hold  in  1  freeze stage (debug/hazard unit)
  Reg_Write  in  1  instruction writes a register
  Wb_Sel  in  2  0=ALU, 1=MEM, 2=LINK, 3=reserved
  Load_Type  in  3  0=LW, 1=LB, 2=LBU, 3=LH, 4=LHU
  Rd  in  5  destination register
  ALU_Result  in  32  ALU output; [1:0] is the load byte offset
  Mem_Data  in  32  raw aligned memory word
  Link_PC  in  32  PC+4 for jal/jalr
  Write_Reg  out  1  register file write enable
  W_Addr  out  5  register file write address
  W_Data  out  32  register file write data
  Fwd_Valid  out  1  forwarding source valid
  Fwd_Addr  out  5  forwarding register number
  Fwd_Data  out  32  forwarding data (equals W_Data)
  Misalign_Err  out  1  one-cycle misaligned-load pulse
  Retired  out  RETIRE_W  retired-instruction count

Function
REQ-003 SHALL hold one instruction in a stage register with a valid bit V.
REQ-004 In_Ready SHALL equal !Hold.
REQ-005 Transfer SHALL occur at a rising edge with In_Valid & In_Ready & !Flush; V<=1 and all fields are captured.
REQ-006 With !Hold and no transfer, V SHALL clear at the edge (bubble).
REQ-007 Hold SHALL keep V and all fields unchanged; Flush SHALL clear V at the edge and override Hold and transfer.
REQ-008 Latency SHALL be one cycle: an instruction accepted at edge N drives Write_Reg/W_Addr/W_Data combinationally from the stage register during cycle N+1.
REQ-009 Write_Reg SHALL equal V & Reg_Write & (Rd!=0) & !Hold & !misaligned & (Wb_Sel!=3).
REQ-010 W_Data: Wb_Sel 0 -> ALU_Result; 2 -> Link_PC; 1 -> load-extracted data.
REQ-011 Load extraction, offset off=ALU_Result[1:0], little-endian: LW whole word; LB/LBU byte at off, sign/zero-extended; LH/LHU halfword at off[1], sign/zero-extended.
REQ-012 Misaligned SHALL mean Wb_Sel=1 with LW and off!=0, or LH/LHU with off[0]=1; the write is suppressed.
REQ-013 Misalign_Err SHALL pulse exactly once per misaligned instruction, in its first valid, non-held cycle.
REQ-014 Fwd_Valid/Fwd_Addr/Fwd_Data SHALL equal Write_Reg/W_Addr/W_Data.
REQ-015 Retired SHALL increment by 1 for each valid instruction leaving the stage unheld, including suppressed writes, and wrap modulo 2^RETIRE_W; a flushed instruction SHALL NOT count.
REQ-016 Load_Type 5-7 with Wb_Sel=1 SHALL behave as LW.

Reset
REQ-017 Reset low SHALL immediately clear V, Retired and all stage fields to 0; Write_Reg, Fwd_Valid and Misalign_Err are then 0.
REQ-018 Reset asserted mid-hold or mid-write SHALL abandon the instruction with no write; the first transfer SHALL be accepted at the first edge after release.

Structure
REQ-019 Wb_Sel and Load_Type encodings SHALL live in the shared CPU constants package.
REQ-020 Load extraction SHALL be a combinational sub-module, load_extract.

Verification
REQ-021 ALU write: Rd=5, Wb_Sel=0, ALU_Result=0x12345678 -> next cycle Write_Reg=1, W_Addr=5, W_Data=0x12345678, Retired=1.
REQ-022 LB sign extension: Mem_Data=0x80FF7F01, off=2 -> W_Data=0xFFFFFFFF; LBU off=3 -> 0x00000080; LH off=2 -> 0xFFFF80FF.
REQ-023 Misaligned LW, off=1 -> Write_Reg=0, one-cycle Misalign_Err pulse, Retired increments.
REQ-024 Rd=0 jal, Link_PC=0x400 -> Write_Reg=0, Retired increments.
REQ-025 Hold for 3 cycles with a held instruction -> In_Ready=0, Write_Reg=0, Retired unchanged; on release one write.
REQ-026 Flush with Hold=1 and In_Valid=1 -> V=0 next cycle, no write, Retired unchanged; Reset low mid-hold -> all outputs 0 immediately.
